// File: rtl/dispense_pkg.sv
// Shared types and default timing for the dispense sequencer slice.
package dispense_pkg;

   localparam int unsigned DEF_DEPTH         = 4;
   localparam int unsigned DEF_MOTOR_CYCLES  = 8;
   localparam int unsigned DEF_TIMEOUT       = 32;
   localparam int unsigned DEF_CHANGE_CYCLES = 4;
   localparam int unsigned DEF_CNT_W         = 16;

   typedef enum logic [2:0] {
      IDLE,
      MOTOR,
      WAIT_DROP,
      CHG_OR_DONE,
      CHANGE,
      FAULT
   } state_t;

   typedef struct packed {
      logic change;
   } vend_entry_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dispense_fifo.sv
// Vend-event FIFO: DEPTH entries, pointers carry one extra wrap bit for full/empty.
module dispense_fifo
   import dispense_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  vend_entry_t              wr_data_i,
   input  logic                     pop_i,
   output vend_entry_t              rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   vend_entry_t   mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;
   logic          do_push;
   logic          do_pop;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/dispense_sequencer.sv
// Dispense sequencer: queues vend events and runs motor / drop-wait / change per event.
// Optional build macro DISPENSE_RETRY_EN: one motor retry after the first drop timeout.
module dispense_sequencer
   import dispense_pkg::*;
#(
   parameter int unsigned DEPTH         = DEF_DEPTH,
   parameter int unsigned MOTOR_CYCLES  = DEF_MOTOR_CYCLES,
   parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
   parameter int unsigned CHANGE_CYCLES = DEF_CHANGE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     vend_req,
   input  logic                     vend_change,
   input  logic                     drop_sensor,
   input  logic                     fault_clr,
   output logic                     motor_on,
   output logic                     change_sol,
   output logic                     vend_done,
   output logic                     req_drop,
   output logic                     fault,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   q_level,
   output logic [CNT_W-1:0]         vend_count
);

   localparam int unsigned TW = $clog2(max3(MOTOR_CYCLES, TIMEOUT, CHANGE_CYCLES) + 1);
   localparam logic [TW-1:0] MOTOR_LAST   = TW'(MOTOR_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] CHANGE_LAST  = TW'(CHANGE_CYCLES - 1);

   state_t              state_q;
   logic [TW-1:0]       timer_q;
   logic                early_drop_q;
   logic                chg_q;
   logic                motor_on_q;
   logic                change_sol_q;
   logic                vend_done_q;
   logic                req_drop_q;
   logic                fault_q;
   logic [CNT_W-1:0]    vend_count_q;
`ifdef DISPENSE_RETRY_EN
   logic                retry_q;
`endif

   vend_entry_t         push_entry;
   vend_entry_t         head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;

   assign push_entry.change = vend_change;
   assign pop               = (state_q == IDLE) && !fifo_empty;

   dispense_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (vend_req),
      .wr_data_i (push_entry),
      .pop_i     (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (q_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         early_drop_q <= 1'b0;
         chg_q        <= 1'b0;
         motor_on_q   <= 1'b0;
         change_sol_q <= 1'b0;
         vend_done_q  <= 1'b0;
         req_drop_q   <= 1'b0;
         fault_q      <= 1'b0;
         vend_count_q <= '0;
`ifdef DISPENSE_RETRY_EN
         retry_q      <= 1'b0;
`endif
      end else begin
         vend_done_q <= 1'b0;
         // full is the pre-pop view, so a coinciding pop never rescues the request
         req_drop_q  <= vend_req && fifo_full;
         unique case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  chg_q        <= head.change;
                  early_drop_q <= 1'b0;
                  timer_q      <= '0;
                  motor_on_q   <= 1'b1;
                  state_q      <= MOTOR;
`ifdef DISPENSE_RETRY_EN
                  retry_q      <= 1'b0;
`endif
               end
            end
            MOTOR: begin
               if (drop_sensor) early_drop_q <= 1'b1;
               if (timer_q == MOTOR_LAST) begin
                  motor_on_q <= 1'b0;
                  timer_q    <= '0;
                  state_q    <= (early_drop_q || drop_sensor) ? CHG_OR_DONE : WAIT_DROP;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            WAIT_DROP: begin
               if (drop_sensor) begin
                  state_q <= CHG_OR_DONE;
               end else if (timer_q == TIMEOUT_LAST) begin
`ifdef DISPENSE_RETRY_EN
                  if (!retry_q) begin
                     retry_q      <= 1'b1;
                     early_drop_q <= 1'b0;
                     timer_q      <= '0;
                     motor_on_q   <= 1'b1;
                     state_q      <= MOTOR;
                  end else begin
                     fault_q <= 1'b1;
                     state_q <= FAULT;
                  end
`else
                  fault_q <= 1'b1;
                  state_q <= FAULT;
`endif
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            CHG_OR_DONE: begin
               timer_q <= '0;
               if (chg_q) begin
                  change_sol_q <= 1'b1;
                  state_q      <= CHANGE;
               end else begin
                  vend_done_q  <= 1'b1;
                  vend_count_q <= vend_count_q + CNT_W'(1);
                  state_q      <= IDLE;
               end
            end
            CHANGE: begin
               if (timer_q == CHANGE_LAST) begin
                  change_sol_q <= 1'b0;
                  vend_done_q  <= 1'b1;
                  vend_count_q <= vend_count_q + CNT_W'(1);
                  state_q      <= IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            FAULT: begin
               if (fault_clr) begin
                  fault_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign motor_on   = motor_on_q;
   assign change_sol = change_sol_q;
   assign vend_done  = vend_done_q;
   assign req_drop   = req_drop_q;
   assign fault      = fault_q;
   assign vend_count = vend_count_q;
   assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer; a small CNT_W instance covers counter wrap.
module tb_dispense_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vend_req = 1'b0;
   logic        vend_change = 1'b0;
   logic        drop_sensor = 1'b0;
   logic        fault_clr = 1'b0;
   logic        motor_on, change_sol, vend_done, req_drop, fault, busy;
   logic [2:0]  q_level;
   logic [15:0] vend_count;

   logic        w_req = 1'b0;
   logic        w_motor, w_chg_sol, w_done, w_drop_o, w_fault, w_busy;
   logic [2:0]  w_level;
   logic [2:0]  w_count;

   int n_checks = 0;
   int n_fail   = 0;

   dispense_sequencer #(
      .DEPTH(4), .MOTOR_CYCLES(8), .TIMEOUT(32), .CHANGE_CYCLES(4), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .vend_req(vend_req), .vend_change(vend_change),
      .drop_sensor(drop_sensor), .fault_clr(fault_clr), .motor_on(motor_on),
      .change_sol(change_sol), .vend_done(vend_done), .req_drop(req_drop),
      .fault(fault), .busy(busy), .q_level(q_level), .vend_count(vend_count)
   );

   dispense_sequencer #(
      .DEPTH(4), .MOTOR_CYCLES(2), .TIMEOUT(4), .CHANGE_CYCLES(1), .CNT_W(3)
   ) u_wrap (
      .clk(clk), .reset(reset), .vend_req(w_req), .vend_change(1'b0),
      .drop_sensor(1'b1), .fault_clr(1'b0), .motor_on(w_motor),
      .change_sol(w_chg_sol), .vend_done(w_done), .req_drop(w_drop_o),
      .fault(w_fault), .busy(w_busy), .q_level(w_level), .vend_count(w_count)
   );

   always #5 clk = ~clk;

   int  motor_hi = 0;
   int  chg_hi   = 0;
   int  bursts   = 0;
   bit  motor_prev = 1'b0;
   bit  chg_flag   = 1'b0;
   bit  done_log[$];

   always @(posedge clk) begin
      #1;
      if (motor_on === 1'b1) motor_hi++;
      if (change_sol === 1'b1) begin
         chg_hi++;
         chg_flag = 1'b1;
      end
      if (motor_on === 1'b1 && !motor_prev) bursts++;
      motor_prev = (motor_on === 1'b1);
      if (vend_done === 1'b1) begin
         done_log.push_back(chg_flag);
         chg_flag = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // n counts edges since the push edge; returns edge index of done/fault and first motor
   task automatic run_event(input bit chg, input int drop_at, input int clr_at,
                            output int n_end, output int n_motor, output bit faulted);
      int n;
      vend_change = chg;
      vend_req    = 1'b1;
      tick;
      vend_req    = 1'b0;
      vend_change = 1'b0;
      n = 1; n_motor = 0; n_end = 0; faulted = 1'b0;
      while (n < 150) begin
         if (motor_on === 1'b1 && n_motor == 0) n_motor = n;
         drop_sensor = (n == drop_at);
         fault_clr   = (n == clr_at);
         tick;
         n++;
         if (vend_done === 1'b1) begin n_end = n; break; end
         if (fault === 1'b1) begin faulted = 1'b1; n_end = n; break; end
      end
      drop_sensor = 1'b0;
      fault_clr   = 1'b0;
   endtask

   initial begin
      int       n_end, n_motor, m0, c0, b0, log0, got;
      bit       faulted;
      bit [4:0] pat;

      // reset state
      tick; tick;
      chk("rst_motor", 32'(motor_on), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_level", 32'(q_level), 32'(0));
      chk("rst_count", 32'(vend_count), 32'(0));
      chk("rst_fault", 32'(fault), 32'(0));
      reset = 1'b0;
      tick;

      // 1: single vend, drop in WAIT_DROP cycle 3
      m0 = motor_hi; c0 = chg_hi;
      run_event(1'b0, 13, -1, n_end, n_motor, faulted);
      chk("t1_motor_start", 32'(n_motor), 32'(2));
      chk("t1_done_edge", 32'(n_end), 32'(15));
      chk("t1_motor_cycles", 32'(motor_hi - m0), 32'(8));
      chk("t1_no_change", 32'(chg_hi - c0), 32'(0));
      chk("t1_count", 32'(vend_count), 32'(1));
      tick;
      chk("t1_done_pulse", 32'(vend_done), 32'(0));
      chk("t1_idle", 32'(busy), 32'(0));

      // 2: change event, drop during MOTOR skips WAIT_DROP
      m0 = motor_hi; c0 = chg_hi;
      run_event(1'b1, 4, -1, n_end, n_motor, faulted);
      chk("t2_done_edge", 32'(n_end), 32'(15));
      chk("t2_motor_cycles", 32'(motor_hi - m0), 32'(8));
      chk("t2_change_cycles", 32'(chg_hi - c0), 32'(4));
      chk("t2_count", 32'(vend_count), 32'(2));
      tick;

      // 3: five requests while busy, fifth dropped, FIFO order kept
      log0 = done_log.size();
      c0 = chg_hi;
      pat = 5'b10101;
      drop_sensor = 1'b1;
      vend_req = 1'b1; vend_change = 1'b0;
      tick;
      vend_req = 1'b0;
      tick;
      chk("t3_busy", 32'(busy), 32'(1));
      for (int i = 0; i < 5; i++) begin
         vend_req = 1'b1; vend_change = pat[i];
         tick;
         chk($sformatf("t3_req_drop_%0d", i), 32'(req_drop), 32'(i == 4));
      end
      vend_req = 1'b0; vend_change = 1'b0;
      chk("t3_level_full", 32'(q_level), 32'(4));
      tick;
      chk("t3_req_drop_clear", 32'(req_drop), 32'(0));
      got = 0;
      for (int i = 0; i < 300 && got < 5; i++) begin
         tick;
         if (vend_done === 1'b1) got++;
      end
      chk("t3_done_count", 32'(got), 32'(5));
      chk("t3_log_size", 32'(done_log.size() - log0), 32'(5));
      for (int i = 0; i < 5; i++)
         if (log0 + i < done_log.size())
            chk($sformatf("t3_order_%0d", i), 32'(done_log[log0 + i]), 32'(i % 2));
      chk("t3_change_cycles", 32'(chg_hi - c0), 32'(8));
      chk("t3_count", 32'(vend_count), 32'(7));
      drop_sensor = 1'b0;
      tick;
      chk("t3_idle", 32'(busy), 32'(0));
      fault_clr = 1'b1;
      tick;
      fault_clr = 1'b0;
      chk("clr_idle_ignored", 32'(fault), 32'(0));

      // 4: no drop -> fault; fault_clr inside WAIT_DROP must be ignored
      b0 = bursts;
      run_event(1'b0, -1, 20, n_end, n_motor, faulted);
      chk("t4_faulted", 32'(faulted), 32'(1));
`ifdef DISPENSE_RETRY_EN
      chk("t4_fault_edge", 32'(n_end), 32'(82));
      chk("t4_bursts", 32'(bursts - b0), 32'(2));
`else
      chk("t4_fault_edge", 32'(n_end), 32'(42));
      chk("t4_bursts", 32'(bursts - b0), 32'(1));
`endif
      chk("t4_motor_off", 32'(motor_on), 32'(0));
      chk("t4_count_kept", 32'(vend_count), 32'(7));
      vend_req = 1'b1; vend_change = 1'b1;
      tick;
      vend_change = 1'b0;
      tick;
      vend_req = 1'b0;
      chk("t4_queue_in_fault", 32'(q_level), 32'(2));
      chk("t4_fault_sticky", 32'(fault), 32'(1));
      fault_clr = 1'b1;
      tick;
      fault_clr = 1'b0;
      chk("t4_fault_fall", 32'(fault), 32'(0));
      chk("t4_level_after_clr", 32'(q_level), 32'(2));
      tick;
      chk("t4_next_motor", 32'(motor_on), 32'(1));
      chk("t4_next_pop", 32'(q_level), 32'(1));
      drop_sensor = 1'b1;
      got = 0;
      for (int i = 0; i < 100 && got < 2; i++) begin
         tick;
         if (vend_done === 1'b1) got++;
      end
      drop_sensor = 1'b0;
      chk("t4_resume_done", 32'(got), 32'(2));
      chk("t4_count_after", 32'(vend_count), 32'(9));
      tick;

      // 5: asynchronous reset mid-MOTOR
      vend_req = 1'b1;
      tick;
      tick;
      vend_req = 1'b0;
      tick; tick;
      chk("t5_motor_before", 32'(motor_on), 32'(1));
      #2 reset = 1'b1;
      #1;
      chk("t5_motor_async", 32'(motor_on), 32'(0));
      chk("t5_level_clr", 32'(q_level), 32'(0));
      chk("t5_count_clr", 32'(vend_count), 32'(0));
      chk("t5_busy_clr", 32'(busy), 32'(0));
      tick;
      reset = 1'b0;
      tick;
      chk("t5_idle_after", 32'(busy), 32'(0));

      // counter wrap on the narrow instance
      w_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         got = 0;
         for (int i = 0; i < 40 && got == 0; i++) begin
            tick;
            if (w_done === 1'b1) got = 1;
         end
         chk($sformatf("wrap_done_%0d", k), 32'(got), 32'(1));
         chk($sformatf("wrap_count_%0d", k), 32'(w_count), 32'(k % 8));
      end
      w_req = 1'b0;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
